// File: rtl/packer8_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : packer8_if
// Brief    : Serial-bit input and packed-word output bundle for packer8.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
interface packer8_if;
   logic       bit_in;
   logic       bit_valid;
   logic       bit_ready;
   logic       flush;
   logic [7:0] out;
   logic [3:0] out_count;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output bit_in, bit_valid, flush, out_ready,
      input  bit_ready, out, out_count, out_valid
   );

   modport slave (
      input  bit_in, bit_valid, flush, out_ready,
      output bit_ready, out, out_count, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/packer8.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : packer8
// Brief    : Packs serial bits into 8-bit words; flush emits a zero-padded
//            partial word with its bit count.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module packer8 #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  wire logic clk,
   input  wire logic rst_n,
   packer8_if.slave  bus
);

   localparam logic [2:0] c_last_pos = 3'd7;
   localparam logic [3:0] c_full_cnt = 4'd8;

   logic [7:0] r_acc;
   logic [2:0] r_cnt;
   logic       r_flush_pend;
   logic [7:0] r_out;
   logic [3:0] r_out_count;
   logic       r_out_valid;

   logic       w_out_slot_free;
   logic       w_bit_ready;
   logic       w_accept;
   logic       w_complete;
   logic       w_flush_set;
   logic       w_load_partial;
   logic [2:0] w_pos;
   logic [7:0] w_acc_next;

   assign w_out_slot_free = !r_out_valid || bus.out_ready;
   // Last bit position needs a free output slot since it loads the word.
   assign w_bit_ready     = !r_flush_pend && (r_cnt != c_last_pos || w_out_slot_free);
   assign w_accept        = bus.bit_valid && w_bit_ready;
   assign w_complete      = w_accept && (r_cnt == c_last_pos);
   assign w_flush_set     = bus.flush && !w_complete && (r_cnt != 3'd0 || w_accept);
   assign w_load_partial  = r_flush_pend && w_out_slot_free;
   assign w_pos           = LSB_FIRST ? r_cnt : (c_last_pos - r_cnt);

   always_comb begin
      w_acc_next = r_acc;
      if (w_accept) begin
         w_acc_next[w_pos] = bus.bit_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc        <= 8'd0;
         r_cnt        <= 3'd0;
         r_flush_pend <= 1'b0;
         r_out        <= 8'd0;
         r_out_count  <= 4'd0;
         r_out_valid  <= 1'b0;
      end else if (w_complete) begin
         r_out        <= w_acc_next;
         r_out_count  <= c_full_cnt;
         r_out_valid  <= 1'b1;
         r_acc        <= 8'd0;
         r_cnt        <= 3'd0;
      end else if (w_load_partial) begin
         // Accept is blocked while pending, so acc/cnt are already final.
         r_out        <= r_acc;
         r_out_count  <= {1'b0, r_cnt};
         r_out_valid  <= 1'b1;
         r_acc        <= 8'd0;
         r_cnt        <= 3'd0;
         r_flush_pend <= 1'b0;
      end else begin
         if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
         r_acc        <= w_acc_next;
         r_cnt        <= w_accept ? (r_cnt + 3'd1) : r_cnt;
         r_flush_pend <= r_flush_pend || w_flush_set;
      end
   end

   assign bus.bit_ready = w_bit_ready;
   assign bus.out       = r_out;
   assign bus.out_count = r_out_count;
   assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire
